// File: rtl/diff_of_n.sv
// Sequential subtractor: loads a starting value, then removes N operands (each with
// borrow-in) one per valid/ready handshake, reporting remainder, sticky underflow and done.
module diff_of_n #(
  parameter int N  = 8,
  parameter int DW = 4,
  parameter int AW = 7
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [AW-1:0] init_i,
  input  logic [DW-1:0] din_i,
  input  logic          bin_i,
  input  logic          din_valid_i,
  output logic          din_ready_o,
  output logic [AW-1:0] result_o,
  output logic          borrow_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [3:0]    count_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [3:0] LAST = 4'(N - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] result_q, result_d;
  logic          borrow_q, borrow_d;
  logic [3:0]    count_q, count_d;
  logic [AW:0]   diff;

  // One extra bit on the left catches the step borrow.
  assign diff = {1'b0, result_q}
              - {{(AW + 1 - DW){1'b0}}, din_i}
              - {{AW{1'b0}}, bin_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      borrow_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      borrow_q <= borrow_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    borrow_d = borrow_q;
    count_d  = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          result_d = init_i;
          borrow_d = 1'b0;
          count_d  = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (din_valid_i) begin
          result_d = diff[AW-1:0];
          borrow_d = borrow_q | diff[AW];
          count_d  = count_q + 4'd1;
          if (count_q == LAST) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign din_ready_o = (state_q == S_RUN);
  assign busy_o      = (state_q == S_RUN) || (state_q == S_DONE);
  assign done_o      = (state_q == S_DONE);
  assign result_o    = result_q;
  assign borrow_o    = borrow_q;
  assign count_o     = count_q;

endmodule

// File: tb/tb_diff_of_n.sv
// Self-checking bench for diff_of_n: integer-arithmetic reference model compared every
// cycle, plus directed scenarios with hand-computed literal results.
module tb_diff_of_n;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] init = '0;
  logic [3:0] din = '0;
  logic       bin = 1'b0;
  logic       din_valid = 1'b0;
  logic       din_ready, borrow, busy, done;
  logic [6:0] result;
  logic [3:0] count;

  int total = 0;
  int passed = 0;
  bit cmp_en = 1'b0;
  int done_pulses = 0;

  // reference model: phase 0=idle, 1=run, 2=done
  int m_phase = 0;
  int m_res = 0;
  int m_bor = 0;
  int m_cnt = 0;

  diff_of_n #(.N(N), .DW(4), .AW(7)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .init_i(init),
    .din_i(din), .bin_i(bin), .din_valid_i(din_valid),
    .din_ready_o(din_ready), .result_o(result), .borrow_o(borrow),
    .busy_o(busy), .done_o(done), .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
  endtask

  always @(posedge clk or posedge rst) begin
    int t;
    if (rst) begin
      m_phase = 0; m_res = 0; m_bor = 0; m_cnt = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
             m_res = int'(init); m_bor = 0; m_cnt = 0; m_phase = 1;
           end
        1: if (din_valid) begin
             t = m_res - int'(din) - int'(bin);
             if (t < 0) m_bor = 1;
             m_res = (t + 256) % 128;
             m_cnt = m_cnt + 1;
             if (m_cnt == N) m_phase = 2;
           end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (done) done_pulses++;
    if (cmp_en && !rst) begin
      chk("result", int'(result), m_res);
      chk("borrow", int'(borrow), m_bor);
      chk("count", int'(count), m_cnt);
      chk("din_ready", int'(din_ready), int'(m_phase == 1));
      chk("busy", int'(busy), int'(m_phase != 0));
      chk("done", int'(done), int'(m_phase == 2));
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start(input logic [6:0] v);
    start = 1'b1; init = v;
    cyc();
    start = 1'b0;
  endtask

  task automatic op(input logic [3:0] d, input logic b);
    din = d; bin = b; din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
  endtask

  initial begin
    int p0;
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    cyc(); cyc();
    chk("reset_result", int'(result), 0);
    chk("reset_ready", int'(din_ready), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;
    cmp_en = 1'b1;
    cyc();

    // reset mid-run
    do_start(7'd100);
    op(4'd5, 1'b0); op(4'd5, 1'b0); op(4'd5, 1'b0);
    chk("pre_reset_result", int'(result), 85);
    chk("pre_reset_count", int'(count), 3);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("async_rst_result", int'(result), 0);
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_ready", int'(din_ready), 0);
    @(negedge clk); rst = 1'b0;
    cyc();
    chk("post_rst_idle_busy", int'(busy), 0);

    // basic run: done lands in cycle 9 counting the start cycle as 0
    p0 = done_pulses;
    do_start(7'd100);
    chk("start_count", int'(count), 0);
    for (int i = 0; i < 8; i++) op(4'd5, 1'b0);
    chk("basic_done_at_9", int'(done), 1);
    chk("basic_result", int'(result), 60);
    chk("basic_borrow", int'(borrow), 0);
    cyc();
    chk("basic_done_pulses", done_pulses - p0, 1);
    chk("basic_hold_result", int'(result), 60);

    // borrow-in with bubbles: 50-4-1-16-10 = 19
    do_start(7'd50);
    op(4'd3, 1'b1);
    cyc();
    op(4'd0, 1'b1);
    op(4'd15, 1'b1);
    for (int i = 0; i < 5; i++) begin op(4'd2, 1'b0); if (i == 1) cyc(); end
    chk("bin_done", int'(done), 1);
    chk("bin_result", int'(result), 19);
    chk("bin_borrow", int'(borrow), 0);
    chk("bin_count", int'(count), 8);
    cyc();

    // handshake gating: valid in IDLE, start pulsed in DONE
    din = 4'd7; bin = 1'b1; din_valid = 1'b1;
    cyc(); cyc();
    chk("idle_drop_count", int'(count), 8);
    chk("idle_drop_result", int'(result), 19);
    din_valid = 1'b0;

    // underflow/wrap: 10 - 8*16 wraps to 10, borrow sticky from step 1
    do_start(7'd10);
    op(4'd15, 1'b1);
    chk("uf_step1_borrow", int'(borrow), 1);
    chk("uf_step1_result", int'(result), 122);
    for (int i = 0; i < 7; i++) op(4'd15, 1'b1);
    chk("uf_result", int'(result), 10);
    chk("uf_borrow", int'(borrow), 1);
    start = 1'b1; din_valid = 1'b1;
    cyc();
    start = 1'b0;
    chk("done_start_ignored", int'(busy), 0);
    cyc();
    chk("still_idle", int'(busy), 0);
    din_valid = 1'b0;

    // back-to-back: start on the first IDLE cycle after done
    for (int i = 0; i < 8; i++) begin
      if (i == 0) do_start(7'd20);
      op(4'd1, 1'b0);
    end
    chk("b2b_first_done", int'(done), 1);
    cyc();
    do_start(7'd127);
    chk("b2b_result", int'(result), 127);
    chk("b2b_borrow", int'(borrow), 0);
    chk("b2b_count", int'(count), 0);
    op(4'd0, 1'b0);
    chk("b2b_zero_op", int'(result), 127);
    cyc(); cyc();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
